// File: rtl/i2c_cmd_sequencer.sv
// Command/response FIFO front end that feeds the I2C master engine one transaction at a time.
// Define I2C_SEQ_RETRY_EN to re-issue nacked transactions up to MAX_RETRY extra times.
module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 200000
`ifdef I2C_SEQ_RETRY_EN
  , parameter int MAX_RETRY      = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [6:0] rsp_addr,
    output logic [1:0] rsp_err,
    output logic       m_start,
    output logic       m_rw_bit,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_tx_data,
    input  logic [7:0] m_rx_data,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_error,
    output logic       seq_busy,
    output logic [7:0] err_count
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CAW:0]    CMD_FULL = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW:0]    RSP_FULL = (RAW + 1)'(RSP_DEPTH);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      ERR_OK   = 2'b00;
    localparam logic [1:0]      ERR_NACK = 2'b01;
    localparam logic [1:0]      ERR_TMO  = 2'b10;

    // state     | meaning
    // S_IDLE    | wait for a queued command, a free response slot and an idle master
    // S_ISSUE   | one-cycle m_start pulse, timeout counter cleared
    // S_WAIT_DONE | count towards timeout until m_done
    // S_RESP    | write the result word into the response FIFO
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [15:0]    cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_q, cmd_rd_q;
    logic [CAW:0]   cmd_cnt_q;
    logic           cmd_push, cmd_pop, cmd_empty, cmd_full;

    logic [16:0]    rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] rsp_wr_q, rsp_rd_q;
    logic [RAW:0]   rsp_cnt_q;
    logic           rsp_push, rsp_pop, rsp_space;

    logic           hold_rw_q, hold_rw_d;
    logic [6:0]     hold_addr_q, hold_addr_d;
    logic [7:0]     hold_data_q, hold_data_d;
    logic [7:0]     res_data_q, res_data_d;
    logic [1:0]     res_err_q, res_err_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     err_cnt_q, err_cnt_d;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTW-1:0] RETRY_LIMIT = RTW'(MAX_RETRY);
    logic [RTW-1:0] retry_q, retry_d;
`endif

    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_full  = (cmd_cnt_q == CMD_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign cmd_ready = !cmd_full || cmd_pop;
    assign cmd_push  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + 1'b1;
            if (cmd_pop)  cmd_rd_q <= cmd_rd_q + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
                2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
                default: cmd_cnt_q <= cmd_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_q] <= {cmd_rw, cmd_addr, cmd_data};
    end

    assign rsp_valid = (rsp_cnt_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_space = (rsp_cnt_q != RSP_FULL) || rsp_pop;
    assign rsp_push  = (state_q == S_RESP);
    assign {rsp_addr, rsp_data, rsp_err} = rsp_mem[rsp_rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) rsp_mem[i] <= '0;
        end else begin
            if (rsp_push) begin
                rsp_mem[rsp_wr_q] <= {hold_addr_q, res_data_q, res_err_q};
                rsp_wr_q          <= rsp_wr_q + 1'b1;
            end
            if (rsp_pop) rsp_rd_q <= rsp_rd_q + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
                2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
                default: rsp_cnt_q <= rsp_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_rw_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            res_data_q  <= '0;
            res_err_q   <= ERR_OK;
            tmo_q       <= '0;
            err_cnt_q   <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_rw_q   <= hold_rw_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_pop     = 1'b0;
        hold_rw_d   = hold_rw_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        tmo_d       = tmo_q;
        err_cnt_d   = err_cnt_q;
`ifdef I2C_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef I2C_SEQ_RETRY_EN
                retry_d = '0;
`endif
                if (!cmd_empty && rsp_space && !m_busy) begin
                    cmd_pop = 1'b1;
                    {hold_rw_d, hold_addr_d, hold_data_d} = cmd_mem[cmd_rd_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tmo_d = tmo_q + 1'b1;
                if (m_done) begin
                    res_data_d = hold_rw_q ? m_rx_data : hold_data_q;
                    if (!m_ack_error) begin
                        res_err_d = ERR_OK;
                        state_d   = S_RESP;
                    end else begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            res_err_d = ERR_NACK;
                            state_d   = S_RESP;
                        end
`else
                        res_err_d = ERR_NACK;
                        state_d   = S_RESP;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d = hold_rw_q ? 8'h00 : hold_data_q;
                    res_err_d  = ERR_TMO;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (res_err_q != ERR_OK && err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_start      = (state_q == S_ISSUE);
    assign m_rw_bit     = hold_rw_q;
    assign m_slave_addr = hold_addr_q;
    assign m_tx_data    = hold_data_q;
    assign seq_busy     = (state_q != S_IDLE) || !cmd_empty;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a small behavioural I2C master model.
module tb_i2c_cmd_sequencer;

    localparam int TMO = 40;
`ifdef I2C_SEQ_RETRY_EN
    localparam int EXP_NACK_STARTS = 3;
`else
    localparam int EXP_NACK_STARTS = 1;
`endif

    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [6:0] rsp_addr;
    logic [1:0] rsp_err;
    logic       m_start, m_rw_bit;
    logic [6:0] m_slave_addr;
    logic [7:0] m_tx_data, m_rx_data;
    logic       m_busy, m_done, m_ack_error;
    logic       seq_busy;
    logic [7:0] err_count;

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int mdl_mode  = 0;   // 0 ack, 1 nack every attempt, 2 never completes
    logic [7:0] mdl_rx = 8'h00;

    i2c_cmd_sequencer #(
        .CMD_DEPTH(4),
        .RSP_DEPTH(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .m_start(m_start), .m_rw_bit(m_rw_bit), .m_slave_addr(m_slave_addr),
        .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_busy(m_busy),
        .m_done(m_done), .m_ack_error(m_ack_error),
        .seq_busy(seq_busy), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;
    always @(negedge clk) if (m_start === 1'b1) start_cnt++;

    // Master answers with a one-cycle m_done in the first WAIT_DONE cycle.
    initial begin
        m_done = 1'b0; m_ack_error = 1'b0; m_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            m_done = 1'b0; m_ack_error = 1'b0;
            if (m_start === 1'b1 && mdl_mode != 2) begin
                @(negedge clk);
                m_done = 1'b1; m_ack_error = (mdl_mode == 1); m_rx_data = mdl_rx;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL push_accept: cmd_ready stayed %b, want 1 within 100 cycles", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_start(input int lim, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim && !ok; n++) begin
            @(negedge clk);
            if (m_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; m_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        else passed++;
        checks++;
        if ({rsp_valid, m_start, seq_busy} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {rsp_valid, m_start, seq_busy});
        else passed++;
        checks++;
        if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count);
        else passed++;
        checks++;
        if ({rsp_addr, rsp_data, rsp_err} !== 17'd0)
            $display("FAIL reset_rsp_word: got %h want 0", {rsp_addr, rsp_data, rsp_err});
        else passed++;
        checks++;
        if ({m_rw_bit, m_slave_addr, m_tx_data} !== 16'd0)
            $display("FAIL reset_master_if: got %h want 0", {m_rw_bit, m_slave_addr, m_tx_data});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_write();
        int s0;
        mdl_mode = 0; mdl_rx = 8'h3C; s0 = start_cnt;
        push_cmd(1'b0, 7'h55, 8'hFF);
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0 || seq_busy !== 1'b1)
            $display("FAIL write_pop_cycle: m_start=%b seq_busy=%b want 0/1", m_start, seq_busy);
        else passed++;
        @(negedge clk);
        checks++;
        if ({m_start, m_rw_bit, m_slave_addr, m_tx_data} !== {1'b1, 1'b0, 7'h55, 8'hFF})
            $display("FAIL write_issue: got %h want %h",
                     {m_start, m_rw_bit, m_slave_addr, m_tx_data}, {1'b1, 1'b0, 7'h55, 8'hFF});
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL write_rsp_early: rsp_valid=%b want 0", rsp_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_addr, rsp_data, rsp_err} !== {1'b1, 7'h55, 8'hFF, 2'b00})
            $display("FAIL write_rsp: got %h want %h",
                     {rsp_valid, rsp_addr, rsp_data, rsp_err}, {1'b1, 7'h55, 8'hFF, 2'b00});
        else passed++;
        pop_rsp();
        checks++;
        if (start_cnt - s0 !== 1) $display("FAIL write_starts: got %0d want 1", start_cnt - s0);
        else passed++;
        checks++;
        if (err_count !== 8'd0) $display("FAIL write_err_count: got %0d want 0", err_count);
        else passed++;
        checks++;
        if ({seq_busy, m_slave_addr, m_tx_data} !== {1'b0, 7'h55, 8'hFF})
            $display("FAIL write_idle_hold: got %h want %h",
                     {seq_busy, m_slave_addr, m_tx_data}, {1'b0, 7'h55, 8'hFF});
        else passed++;
    endtask

    task automatic test_read();
        int s0; bit ok;
        mdl_mode = 0; mdl_rx = 8'hA5; s0 = start_cnt;
        push_cmd(1'b1, 7'h57, 8'h00);
        wait_rsp(20, ok);
        checks++;
        if (!ok || {rsp_addr, rsp_data, rsp_err} !== {7'h57, 8'hA5, 2'b00})
            $display("FAIL read_rsp: valid=%b got %h want %h", ok,
                     {rsp_addr, rsp_data, rsp_err}, {7'h57, 8'hA5, 2'b00});
        else passed++;
        checks++;
        if (start_cnt - s0 !== 1 || m_rw_bit !== 1'b1)
            $display("FAIL read_issue: starts=%0d rw=%b want 1/1", start_cnt - s0, m_rw_bit);
        else passed++;
        pop_rsp();
    endtask

    task automatic test_busy_hold();
        int s0; bit ok;
        mdl_mode = 0; m_busy = 1'b1; s0 = start_cnt;
        push_cmd(1'b0, 7'h66, 8'h12);
        repeat (6) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 0 || seq_busy !== 1'b1)
            $display("FAIL busy_hold: starts=%0d seq_busy=%b want 0/1", start_cnt - s0, seq_busy);
        else passed++;
        m_busy = 1'b0;
        wait_rsp(20, ok);
        checks++;
        if (!ok || {rsp_addr, rsp_data, rsp_err} !== {7'h66, 8'h12, 2'b00} || start_cnt - s0 !== 1)
            $display("FAIL busy_release: valid=%b got %h starts=%0d want %h/1", ok,
                     {rsp_addr, rsp_data, rsp_err}, start_cnt - s0, {7'h66, 8'h12, 2'b00});
        else passed++;
        pop_rsp();
    endtask

    task automatic test_backpressure();
        int s0; bit ok; bit seen_high;
        mdl_mode = 0; rsp_ready = 1'b0; s0 = start_cnt;
        for (int i = 0; i < 8; i++) push_cmd(1'b0, 7'(7'h10 + i), 8'(8'h80 + i));
        repeat (20) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 4) $display("FAIL bp_starts_stalled: got %0d want 4", start_cnt - s0);
        else passed++;
        checks++;
        if ({rsp_valid, cmd_ready, seq_busy} !== 3'b101)
            $display("FAIL bp_full_flags: got %b want 101", {rsp_valid, cmd_ready, seq_busy});
        else passed++;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h7F; cmd_data = 8'hEE;
        seen_high = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0) seen_high = 1'b1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (seen_high !== 1'b0) $display("FAIL bp_ready_while_full: cmd_ready rose, want 0");
        else passed++;
        checks++;
        if ({rsp_addr, rsp_data, rsp_err} !== {7'h10, 8'h80, 2'b00})
            $display("FAIL bp_rsp0: got %h want %h", {rsp_addr, rsp_data, rsp_err}, {7'h10, 8'h80, 2'b00});
        else passed++;
        pop_rsp();
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 5) $display("FAIL bp_fifth_start: got %0d want 5", start_cnt - s0);
        else passed++;
        for (int i = 1; i < 8; i++) begin
            wait_rsp(40, ok);
            checks++;
            if (!ok || {rsp_addr, rsp_data, rsp_err} !== {7'(7'h10 + i), 8'(8'h80 + i), 2'b00})
                $display("FAIL bp_rsp%0d: valid=%b got %h want %h", i, ok,
                         {rsp_addr, rsp_data, rsp_err}, {7'(7'h10 + i), 8'(8'h80 + i), 2'b00});
            else passed++;
            pop_rsp();
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({rsp_valid, seq_busy} !== 2'b00 || start_cnt - s0 !== 8)
            $display("FAIL bp_drained: flags=%b starts=%0d want 00/8", {rsp_valid, seq_busy}, start_cnt - s0);
        else passed++;
    endtask

    task automatic test_nack();
        int s0; bit ok;
        mdl_mode = 1; s0 = start_cnt;
        push_cmd(1'b0, 7'h30, 8'h11);
        wait_rsp(60, ok);
        checks++;
        if (!ok || {rsp_addr, rsp_data, rsp_err} !== {7'h30, 8'h11, 2'b01})
            $display("FAIL nack_rsp: valid=%b got %h want %h", ok,
                     {rsp_addr, rsp_data, rsp_err}, {7'h30, 8'h11, 2'b01});
        else passed++;
        checks++;
        if (start_cnt - s0 !== EXP_NACK_STARTS)
            $display("FAIL nack_starts: got %0d want %0d", start_cnt - s0, EXP_NACK_STARTS);
        else passed++;
        checks++;
        if (err_count !== 8'd1) $display("FAIL nack_err_count: got %0d want 1", err_count);
        else passed++;
        pop_rsp();
        mdl_mode = 0;
    endtask

    task automatic test_timeout();
        int ts, tr; bit ok_s, ok_r;
        mdl_mode = 2;
        push_cmd(1'b0, 7'h42, 8'h99);
        wait_start(10, ok_s);
        ts = cyc;
        wait_rsp(TMO + 20, ok_r);
        tr = cyc;
        // Timeout is decided TMO cycles after m_start; RESP and the FIFO add two more.
        checks++;
        if (!ok_s || !ok_r || tr - ts !== TMO + 2)
            $display("FAIL timeout_latency: start=%b rsp=%b got %0d want %0d", ok_s, ok_r, tr - ts, TMO + 2);
        else passed++;
        checks++;
        if ({rsp_addr, rsp_data, rsp_err} !== {7'h42, 8'h99, 2'b10})
            $display("FAIL timeout_rsp: got %h want %h", {rsp_addr, rsp_data, rsp_err}, {7'h42, 8'h99, 2'b10});
        else passed++;
        checks++;
        if (err_count !== 8'd2 || seq_busy !== 1'b0)
            $display("FAIL timeout_state: err_count=%0d seq_busy=%b want 2/0", err_count, seq_busy);
        else passed++;
        pop_rsp();
        mdl_mode = 0;
        push_cmd(1'b0, 7'h43, 8'h01);
        wait_rsp(20, ok_r);
        checks++;
        if (!ok_r || {rsp_addr, rsp_data, rsp_err} !== {7'h43, 8'h01, 2'b00} || err_count !== 8'd2)
            $display("FAIL timeout_next_cmd: valid=%b got %h err_count=%0d want %h/2", ok_r,
                     {rsp_addr, rsp_data, rsp_err}, err_count, {7'h43, 8'h01, 2'b00});
        else passed++;
        pop_rsp();
    endtask

    task automatic test_reset_mid();
        int s0; bit ok;
        mdl_mode = 2;
        push_cmd(1'b0, 7'h21, 8'h5A);
        wait_start(10, ok);
        checks++;
        if (!ok) $display("FAIL rstmid_start: m_start not seen, want 1");
        else passed++;
        @(negedge clk);
        s0 = start_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, seq_busy, m_start, err_count} !== {4'b0100, 8'd0})
            $display("FAIL rstmid_state: got %h want %h",
                     {rsp_valid, cmd_ready, seq_busy, m_start, err_count}, {4'b0100, 8'd0});
        else passed++;
        repeat (2 * TMO) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 0 || rsp_valid !== 1'b0)
            $display("FAIL rstmid_quiet: starts=%0d rsp_valid=%b want 0/0", start_cnt - s0, rsp_valid);
        else passed++;
        mdl_mode = 0;
        push_cmd(1'b0, 7'h22, 8'h77);
        wait_rsp(20, ok);
        checks++;
        if (!ok || {rsp_addr, rsp_data, rsp_err} !== {7'h22, 8'h77, 2'b00})
            $display("FAIL rstmid_recover: valid=%b got %h want %h", ok,
                     {rsp_addr, rsp_data, rsp_err}, {7'h22, 8'h77, 2'b00});
        else passed++;
        pop_rsp();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_hold();
        test_backpressure();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
